// File: rtl/vram_arbiter.sv
// vram_arbiter: serves the VRAM requests of NUM_CORES cores on one single-port
// synchronous VRAM, one transaction at a time, with all outputs registered.
// Optional build macro VRAM_ARB_FIXED_PRIO_EN: lowest-index active core wins.
// Without it (default) arbitration is round robin, starting after last_grant.
module vram_arbiter #(
  parameter int unsigned NUM_CORES       = 4,
  parameter int unsigned VRAM_ADDR_WIDTH = 16,
  parameter int unsigned VRAM_WORD_WIDTH = 24,
  parameter int unsigned READ_LATENCY    = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CORES-1:0]                   core_vram_active,
  input  logic [NUM_CORES-1:0]                   core_vram_w,
  input  logic [NUM_CORES*VRAM_ADDR_WIDTH-1:0]   core_vram_addr,
  input  logic [NUM_CORES*VRAM_WORD_WIDTH-1:0]   core_vram_in,
  output logic [VRAM_WORD_WIDTH-1:0]             core_vram_out,
  output logic [NUM_CORES-1:0]                   core_vram_ready,
  output logic                                   mem_en,
  output logic                                   mem_we,
  output logic [VRAM_ADDR_WIDTH-1:0]             mem_addr,
  output logic [VRAM_WORD_WIDTH-1:0]             mem_wdata,
  input  logic [VRAM_WORD_WIDTH-1:0]             mem_rdata,
  output logic [$clog2(NUM_CORES)-1:0]           grant_id,
  output logic                                   busy
);

  localparam int unsigned GID_W = $clog2(NUM_CORES);
  localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                       state, state_nxt;
  logic [CNT_W-1:0]             cnt, cnt_nxt;
  logic [GID_W-1:0]             winner;
  logic                         mem_en_nxt, mem_we_nxt, busy_nxt;
  logic [VRAM_ADDR_WIDTH-1:0]   mem_addr_nxt;
  logic [VRAM_WORD_WIDTH-1:0]   mem_wdata_nxt, out_nxt;
  logic [NUM_CORES-1:0]         ready_nxt;
  logic [GID_W-1:0]             grant_nxt;

  logic [VRAM_ADDR_WIDTH-1:0]   addr_arr  [NUM_CORES];
  logic [VRAM_WORD_WIDTH-1:0]   wdata_arr [NUM_CORES];

  // Split the flattened per-core buses into arrays.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign addr_arr[g]  = core_vram_addr[g*VRAM_ADDR_WIDTH +: VRAM_ADDR_WIDTH];
    assign wdata_arr[g] = core_vram_in[g*VRAM_WORD_WIDTH +: VRAM_WORD_WIDTH];
  end

`ifdef VRAM_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest-index active core wins.
  always_comb begin
    winner = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (core_vram_active[GID_W'(i)]) winner = GID_W'(i);
    end
  end
`else
  logic [GID_W-1:0] last_grant;
  logic [GID_W-1:0] rr_idx;
  logic             rr_found;

  // Round robin: first active core after last_grant, wrapping.
  always_comb begin
    winner   = last_grant;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= int'(NUM_CORES); i++) begin
      rr_idx = GID_W'((int'(last_grant) + i) % int'(NUM_CORES));
      if (!rr_found && core_vram_active[rr_idx]) begin
        winner   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  // Remember the last winner; reset value makes core 0 win first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GID_W'(NUM_CORES - 1);
    end else if (state == S_IDLE && |core_vram_active) begin
      last_grant <= winner;
    end
  end
`endif

  // Next state and next values of all registered outputs.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    out_nxt       = core_vram_out;
    ready_nxt     = '0;
    grant_nxt     = grant_id;
    case (state)
      S_IDLE: begin
        if (|core_vram_active) begin
          state_nxt     = S_ISSUE;
          grant_nxt     = winner;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = core_vram_w[winner];
          mem_addr_nxt  = addr_arr[winner];
          mem_wdata_nxt = wdata_arr[winner];
        end
      end
      S_ISSUE: begin
        // mem_we still holds the latched direction during ISSUE.
        if (mem_we) begin
          state_nxt           = S_DONE;
          ready_nxt[grant_id] = 1'b1;
        end else begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (cnt == CNT_LAST) begin
          state_nxt           = S_DONE;
          out_nxt             = mem_rdata;
          ready_nxt[grant_id] = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      mem_en          <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      core_vram_out   <= '0;
      core_vram_ready <= '0;
      grant_id        <= '0;
      busy            <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      mem_en          <= mem_en_nxt;
      mem_we          <= mem_we_nxt;
      mem_addr        <= mem_addr_nxt;
      mem_wdata       <= mem_wdata_nxt;
      core_vram_out   <= out_nxt;
      core_vram_ready <= ready_nxt;
      grant_id        <= grant_nxt;
      busy            <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: one instance with READ_LATENCY=1 and one with
// READ_LATENCY=3, each with its own behavioural VRAM model.
module tb_vram_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 24;

  typedef struct {
    logic [1:0]    core;
    logic          wr;
    logic [AW-1:0] ad;
    logic [DW-1:0] d;
  } txn_t;

  logic clk = 1'b0;
  logic rst;

  // Instance with READ_LATENCY=1
  logic [N-1:0]    act, w;
  logic [AW-1:0]   addr_a [N];
  logic [DW-1:0]   din_a  [N];
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] din;
  logic [DW-1:0]   vout, mwdata, mrdata;
  logic [N-1:0]    rdy;
  logic            men, mwe, busy;
  logic [AW-1:0]   maddr;
  logic [1:0]      gid;

  // Instance with READ_LATENCY=3
  logic [N-1:0]    act3, w3;
  logic [AW-1:0]   addr3_a [N];
  logic [DW-1:0]   din3_a  [N];
  logic [N*AW-1:0] addr3;
  logic [N*DW-1:0] din3;
  logic [DW-1:0]   vout3, mwdata3, mrdata3;
  logic [N-1:0]    rdy3;
  logic            men3, mwe3, busy3;
  logic [AW-1:0]   maddr3;
  logic [1:0]      gid3;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] mem3    [256];
  logic [DW-1:0] ref_mem [256];
  txn_t          sb [$];
  int            n_cmp = 0;
  int            n_err = 0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign addr[g*AW +: AW]  = addr_a[g];
    assign din[g*DW +: DW]   = din_a[g];
    assign addr3[g*AW +: AW] = addr3_a[g];
    assign din3[g*DW +: DW]  = din3_a[g];
  end

  vram_arbiter #(.NUM_CORES(N), .VRAM_ADDR_WIDTH(AW), .VRAM_WORD_WIDTH(DW), .READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .core_vram_active(act), .core_vram_w(w), .core_vram_addr(addr),
    .core_vram_in(din), .core_vram_out(vout), .core_vram_ready(rdy), .mem_en(men), .mem_we(mwe),
    .mem_addr(maddr), .mem_wdata(mwdata), .mem_rdata(mrdata), .grant_id(gid), .busy(busy));

  vram_arbiter #(.NUM_CORES(N), .VRAM_ADDR_WIDTH(AW), .VRAM_WORD_WIDTH(DW), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .core_vram_active(act3), .core_vram_w(w3), .core_vram_addr(addr3),
    .core_vram_in(din3), .core_vram_out(vout3), .core_vram_ready(rdy3), .mem_en(men3), .mem_we(mwe3),
    .mem_addr(maddr3), .mem_wdata(mwdata3), .mem_rdata(mrdata3), .grant_id(gid3), .busy(busy3));

  always #5 clk = ~clk;

  // VRAM with one cycle read latency.
  always @(posedge clk) begin
    if (men) begin
      if (mwe) mem[maddr[7:0]] <= mwdata;
      else     mrdata <= mem[maddr[7:0]];
    end
  end

  // VRAM with three cycle read latency; random garbage whenever data is not due.
  logic [1:0] p3;
  logic [7:0] a3_0, a3_1;
  always @(posedge clk) begin
    p3      <= {p3[0], men3 & ~mwe3};
    a3_0    <= maddr3[7:0];
    a3_1    <= a3_0;
    mrdata3 <= p3[1] ? mem3[a3_1] : DW'($urandom);
  end

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 32) return 24'h123456;
    return DW'(i * 65793) ^ 24'h5A5A5A;
  endfunction

  task automatic set_core(input bit on3, input logic [1:0] c, input logic a, input logic wr,
                          input logic [AW-1:0] ad, input logic [DW-1:0] d);
    if (on3) begin
      act3[c] = a; w3[c] = wr; addr3_a[c] = ad; din3_a[c] = d;
    end else begin
      act[c] = a; w[c] = wr; addr_a[c] = ad; din_a[c] = d;
    end
  endtask

  // Waits up to budget falling edges for a ready pulse; cyc=-1 on timeout.
  task automatic wait_ready(input bit on3, input int budget, output int cyc, output logic [N-1:0] seen);
    bit hit;
    cyc = -1; seen = '0; hit = 1'b0;
    for (int k = 1; k <= budget && !hit; k++) begin
      @(negedge clk);
      seen = on3 ? rdy3 : rdy;
      if (seen != '0) begin cyc = k; hit = 1'b1; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({men, mwe, busy} !== 3'b000) begin n_err++; $display("FAIL reset_ctl got=%b exp=000", {men, mwe, busy}); end
    n_cmp++; if (rdy !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", rdy); end
    n_cmp++; if ({vout, maddr, mwdata, gid} !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", {vout, maddr, mwdata, gid}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    int cyc; logic [N-1:0] seen; txn_t t;
    set_core(0, 2'd2, 1'b1, 1'b1, 16'h0010, 24'h00ABCD);
    sb.push_back('{2'd2, 1'b1, 16'h0010, 24'h00ABCD});
    @(negedge clk);
    n_cmp++; if ({men, mwe} !== 2'b11) begin n_err++; $display("FAIL wr_issue got=%b exp=11", {men, mwe}); end
    n_cmp++; if ({maddr, mwdata} !== {16'h0010, 24'h00ABCD}) begin n_err++; $display("FAIL wr_bus got=%h exp=%h", {maddr, mwdata}, {16'h0010, 24'h00ABCD}); end
    n_cmp++; if (gid !== 2'd2) begin n_err++; $display("FAIL wr_gid got=%0d exp=2", gid); end
    wait_ready(0, 6, cyc, seen);
    t = sb.pop_front();
    ref_mem[t.ad[7:0]] = t.d;
    n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL wr_latency got=%0d exp=1", cyc); end
    n_cmp++; if (seen !== 4'(1 << t.core)) begin n_err++; $display("FAIL wr_ready got=%b exp=%b", seen, 4'(1 << t.core)); end
    n_cmp++; if (vout !== 24'h0) begin n_err++; $display("FAIL wr_out_hold got=%h exp=0", vout); end
    act[2] = 1'b0;
    @(negedge clk);
    n_cmp++; if ({rdy, busy} !== 5'b0) begin n_err++; $display("FAIL wr_after got=%b exp=00000", {rdy, busy}); end
    n_cmp++; if (mem[8'h10] !== ref_mem[8'h10]) begin n_err++; $display("FAIL wr_mem got=%h exp=%h", mem[8'h10], ref_mem[8'h10]); end
  endtask

  task automatic test_single_read;
    int cyc; logic [N-1:0] seen; txn_t t;
    set_core(0, 2'd0, 1'b1, 1'b0, 16'h0020, 24'h0);
    sb.push_back('{2'd0, 1'b0, 16'h0020, 24'h0});
    @(negedge clk);
    n_cmp++; if ({men, mwe, maddr} !== {2'b10, 16'h0020}) begin n_err++; $display("FAIL rd_issue got=%h exp=%h", {men, mwe, maddr}, {2'b10, 16'h0020}); end
    wait_ready(0, 6, cyc, seen);
    t = sb.pop_front();
    n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL rd_latency got=%0d exp=2", cyc); end
    n_cmp++; if (seen !== 4'(1 << t.core)) begin n_err++; $display("FAIL rd_ready got=%b exp=%b", seen, 4'(1 << t.core)); end
    n_cmp++; if (vout !== 24'h123456) begin n_err++; $display("FAIL rd_data got=%h exp=123456", vout); end
    act[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    int cyc; logic [N-1:0] seen; txn_t t;
    rst = 1'b1;
    for (int i = 0; i < N; i++)
      set_core(0, 2'(i), 1'b1, i[0], AW'(16'h0040 + i), DW'(24'h500000 + i));
    @(negedge clk);
    rst = 1'b0;
`ifdef VRAM_ARB_FIXED_PRIO_EN
    sb.push_back('{2'd0, 1'b0, 16'h0040, 24'h0});
    sb.push_back('{2'd0, 1'b0, 16'h0020, 24'h0});
    sb.push_back('{2'd1, 1'b1, 16'h0041, 24'h500001});
    sb.push_back('{2'd2, 1'b0, 16'h0042, 24'h0});
    sb.push_back('{2'd3, 1'b1, 16'h0043, 24'h500003});
`else
    sb.push_back('{2'd0, 1'b0, 16'h0040, 24'h0});
    sb.push_back('{2'd1, 1'b1, 16'h0041, 24'h500001});
    sb.push_back('{2'd2, 1'b0, 16'h0042, 24'h0});
    sb.push_back('{2'd3, 1'b1, 16'h0043, 24'h500003});
    sb.push_back('{2'd0, 1'b0, 16'h0020, 24'h0});
`endif
    for (int n = 0; n < 5; n++) begin
      wait_ready(0, 12, cyc, seen);
      t = sb.pop_front();
      n_cmp++; if (cyc < 0) begin n_err++; $display("FAIL rr_timeout txn=%0d got=none exp=ready", n); end
      n_cmp++; if (seen !== 4'(1 << t.core)) begin n_err++; $display("FAIL rr_ready txn=%0d got=%b exp=%b", n, seen, 4'(1 << t.core)); end
      n_cmp++; if (gid !== t.core) begin n_err++; $display("FAIL rr_gid txn=%0d got=%0d exp=%0d", n, gid, t.core); end
      if (t.wr) ref_mem[t.ad[7:0]] = t.d;
      else begin
        n_cmp++; if (vout !== ref_mem[t.ad[7:0]]) begin n_err++; $display("FAIL rr_data txn=%0d got=%h exp=%h", n, vout, ref_mem[t.ad[7:0]]); end
      end
      act[t.core] = 1'b0;
      if (n == 0) begin
        @(negedge clk);
        set_core(0, 2'd0, 1'b1, 1'b0, 16'h0020, 24'h0);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_two_requesters;
    int cyc; logic [N-1:0] seen; txn_t t; bit hit;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_core(0, 2'd1, 1'b1, 1'b1, 16'h0050, 24'hC0FFEE);
    set_core(0, 2'd3, 1'b1, 1'b0, 16'h0043, 24'h0);
    sb.push_back('{2'd1, 1'b1, 16'h0050, 24'hC0FFEE});
    sb.push_back('{2'd3, 1'b0, 16'h0043, 24'h0});
    sb.push_back('{2'd0, 1'b0, 16'h0040, 24'h0});
    for (int n = 0; n < 3; n++) begin
      wait_ready(0, 12, cyc, seen);
      t = sb.pop_front();
      n_cmp++; if (seen !== 4'(1 << t.core)) begin n_err++; $display("FAIL two_ready txn=%0d got=%b exp=%b", n, seen, 4'(1 << t.core)); end
      if (t.wr) ref_mem[t.ad[7:0]] = t.d;
      else begin
        n_cmp++; if (vout !== ref_mem[t.ad[7:0]]) begin n_err++; $display("FAIL two_data txn=%0d got=%h exp=%h", n, vout, ref_mem[t.ad[7:0]]); end
      end
      act[t.core] = 1'b0;
      if (n == 0) begin
        hit = 1'b0;
        for (int k = 0; k < 6 && !hit; k++) begin
          @(negedge clk);
          if (busy && gid == 2'd3) hit = 1'b1;
        end
        n_cmp++; if (!hit) begin n_err++; $display("FAIL two_grant3 got=none exp=grant 3"); end
        set_core(0, 2'd0, 1'b1, 1'b0, 16'h0040, 24'h0);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    int cyc; logic [N-1:0] seen; txn_t t;
    set_core(0, 2'd0, 1'b1, 1'b0, 16'h0042, 24'h0);
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, men, rdy} !== 6'b100000) begin n_err++; $display("FAIL mid_wait got=%b exp=100000", {busy, men, rdy}); end
    rst = 1'b1;
    act[0] = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, men, rdy} !== 6'b0) begin n_err++; $display("FAIL mid_ctl got=%b exp=000000", {busy, men, rdy}); end
    n_cmp++; if (vout !== 24'h0) begin n_err++; $display("FAIL mid_out got=%h exp=0", vout); end
    rst = 1'b0;
    set_core(0, 2'd0, 1'b1, 1'b0, 16'h0042, 24'h0);
    sb.push_back('{2'd0, 1'b0, 16'h0042, 24'h0});
    wait_ready(0, 8, cyc, seen);
    t = sb.pop_front();
    n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL mid_latency got=%0d exp=3", cyc); end
    n_cmp++; if (seen !== 4'(1 << t.core)) begin n_err++; $display("FAIL mid_ready got=%b exp=%b", seen, 4'(1 << t.core)); end
    n_cmp++; if (vout !== ref_mem[t.ad[7:0]]) begin n_err++; $display("FAIL mid_data got=%h exp=%h", vout, ref_mem[t.ad[7:0]]); end
    act[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_latency3;
    int cyc; logic [N-1:0] seen; txn_t t;
    logic [1:0] cores [2];
    cores[0] = 2'd1; cores[1] = 2'd3;
    for (int n = 0; n < 2; n++) begin
      set_core(1, cores[n], 1'b1, 1'b0, AW'(16'h0030 + n), 24'h0);
      sb.push_back('{cores[n], 1'b0, AW'(16'h0030 + n), 24'h0});
      @(negedge clk);
      n_cmp++; if ({men3, mwe3, maddr3} !== {2'b10, AW'(16'h0030 + n)}) begin n_err++; $display("FAIL rl3_issue txn=%0d got=%h exp=%h", n, {men3, mwe3, maddr3}, {2'b10, AW'(16'h0030 + n)}); end
      wait_ready(1, 10, cyc, seen);
      t = sb.pop_front();
      n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL rl3_latency txn=%0d got=%0d exp=4", n, cyc); end
      n_cmp++; if (seen !== 4'(1 << t.core)) begin n_err++; $display("FAIL rl3_ready txn=%0d got=%b exp=%b", n, seen, 4'(1 << t.core)); end
      n_cmp++; if (vout3 !== ref_mem[t.ad[7:0]]) begin n_err++; $display("FAIL rl3_data txn=%0d got=%h exp=%h", n, vout3, ref_mem[t.ad[7:0]]); end
      act3[t.core] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem[8'(i)] = init_val(i); mem3[8'(i)] = init_val(i); ref_mem[8'(i)] = init_val(i);
    end
    for (int i = 0; i < N; i++) begin
      set_core(0, 2'(i), 1'b0, 1'b0, '0, '0);
      set_core(1, 2'(i), 1'b0, 1'b0, '0, '0);
    end
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_two_requesters();
    test_reset_mid_read();
    test_read_latency3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=no finish exp=finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
